// File: rtl/pot_scanner.sv
// pot_scanner: free-running round-robin scanner for an MCP3008-compatible
// 10-bit SPI ADC. It converts channels 0..CHANNELS-1 in turn, smooths each
// channel with a first-order IIR filter, and publishes the filtered values
// as one packed bus.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   enable       level; scanning runs while high (the frame in flight always completes)
//   adc_sclk     SPI clock, mode 0 (idles low)
//   adc_cs_n     ADC chip select, active low
//   adc_mosi     command bits to ADC DIN
//   adc_miso     ADC DOUT (asynchronous, double-flopped here)
//   pots         filtered values, channel n in bits [10n+9:10n]
//   sample_valid one-cycle pulse when pots is updated
//   sample_ch    channel updated with the last sample_valid
//   scan_done    one-cycle pulse together with the sample of channel CHANNELS-1
`timescale 1ns/1ps
module pot_scanner #(
    parameter int CHANNELS = 4,
    parameter int CLKDIV   = 8,
    parameter int GUARD    = 16,
    parameter int SMOOTH   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    output logic                  adc_sclk,
    output logic                  adc_cs_n,
    output logic                  adc_mosi,
    input  logic                  adc_miso,
    output logic [CHANNELS*10-1:0] pots,
    output logic                  sample_valid,
    output logic [2:0]            sample_ch,
    output logic                  scan_done
);

    localparam int AW   = 10 + SMOOTH;                        // accumulator width
    localparam int CMAX = (CLKDIV > GUARD) ? CLKDIV : GUARD;
    localparam int CW   = $clog2(CMAX);                       // counts 0..CMAX-1
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [2:0]    CH_LAST    = 3'(CHANNELS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GUARD} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [4:0]      bit_reg, bit_next;
    logic            high_reg, high_next;     // 1 during the SCLK-high half of a bit
    logic [2:0]      ch_reg, ch_next;
    logic            miso_meta_reg, miso_sync_reg;
    logic [9:0]      raw_reg;
    logic            sclk_next, cs_n_next, mosi_next;
    logic            sample_edge;

    // Command frame, bit 0 first: start at bit 7, single-ended at bit 8,
    // channel D2..D0 at bits 9..11, everything else zero.
    function automatic logic frame_bit(input logic [4:0] k, input logic [2:0] c);
        case (k)
            5'd7, 5'd8: return 1'b1;
            5'd9:       return c[2];
            5'd10:      return c[1];
            5'd11:      return c[0];
            default:    return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        high_next  = high_reg;
        ch_next    = ch_reg;
        case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_SETUP;
                    cnt_next   = '0;
                    bit_next   = '0;
                    high_next  = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_reg == HALF_LAST) begin
                    state_next = S_SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!high_reg) begin
                        high_next = 1'b1;
                    end else if (bit_reg == 5'd23) begin
                        state_next = S_DONE;
                        high_next  = 1'b0;
                    end else begin
                        bit_next  = bit_reg + 5'd1;
                        high_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_GUARD;
                cnt_next   = '0;
            end
            S_GUARD: begin
                if (cnt_reg == GUARD_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    ch_next    = (ch_reg == CH_LAST) ? 3'd0 : ch_reg + 3'd1;
                    state_next = enable ? S_SETUP : S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Pin levels are decoded from the next state and registered, so the
        // SPI lines come straight from flops and MOSI only moves when a new
        // bit (low half) begins.
        cs_n_next = !((state_next == S_SETUP) || (state_next == S_SHIFT));
        sclk_next = (state_next == S_SHIFT) && high_next;
        mosi_next = !cs_n_next && frame_bit(bit_next, ch_next);
    end

    // MISO is taken on the last clk of each high half; bits 14..23 carry B9..B0.
    assign sample_edge = (state_reg == S_SHIFT) && high_reg && (cnt_reg == HALF_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            high_reg      <= 1'b0;
            ch_reg        <= '0;
            miso_meta_reg <= 1'b0;
            miso_sync_reg <= 1'b0;
            raw_reg       <= '0;
            adc_cs_n      <= 1'b1;
            adc_sclk      <= 1'b0;
            adc_mosi      <= 1'b0;
            sample_valid  <= 1'b0;
            sample_ch     <= '0;
            scan_done     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            high_reg      <= high_next;
            ch_reg        <= ch_next;
            miso_meta_reg <= adc_miso;
            miso_sync_reg <= miso_meta_reg;
            if (sample_edge && (bit_reg >= 5'd14)) begin
                raw_reg <= {raw_reg[8:0], miso_sync_reg};
            end
            adc_cs_n     <= cs_n_next;
            adc_sclk     <= sclk_next;
            adc_mosi     <= mosi_next;
            sample_valid <= (state_reg == S_DONE);
            scan_done    <= (state_reg == S_DONE) && (ch_reg == CH_LAST);
            if (state_reg == S_DONE) begin
                sample_ch <= ch_reg;
            end
        end
    end

    // Shared filter arithmetic for the channel just converted.
    // acc + r - (acc >> SMOOTH) never goes negative and stays <= 1023 << SMOOTH,
    // so truncating the one-bit-wider intermediate back to AW bits is exact.
    logic [CHANNELS*AW-1:0] acc_flat;
    logic [AW-1:0]          acc_sel;
    logic [AW:0]            acc_sum;

    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_reg == 3'(i)) begin
                acc_sel = acc_flat[i*AW +: AW];
            end
        end
        acc_sum = {1'b0, acc_sel} + (AW+1)'(raw_reg) - (AW+1)'(acc_sel >> SMOOTH);
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [AW-1:0] acc_reg;
            logic          first_reg;   // no sample taken since reset: load directly

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    acc_reg   <= '0;
                    first_reg <= 1'b1;
                end else if ((state_reg == S_DONE) && (ch_reg == 3'(gi))) begin
                    acc_reg   <= first_reg ? (AW'(raw_reg) << SMOOTH) : AW'(acc_sum);
                    first_reg <= 1'b0;
                end
            end

            assign acc_flat[gi*AW +: AW] = acc_reg;
            assign pots[gi*10 +: 10]     = acc_reg[AW-1 -: 10];
        end
    endgenerate

endmodule

// File: tb/tb_pot_scanner.sv
`timescale 1ns/1ps
module tb_pot_scanner;

    localparam int CLKDIV = 8;
    localparam int GUARD  = 16;
    localparam int NCH    = 4;
    localparam int P      = CLKDIV + 48*CLKDIV + 1 + GUARD;   // 409
    localparam int P_EXT  = 4 + 192 + 1 + 2;                  // 199

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, enable, enable_x;

    // main instance (defaults)
    logic             sclk, cs_n, mosi, miso;
    logic [NCH*10-1:0] pots;
    logic             sv, sd;
    logic [2:0]       sch;

    // extremes instance
    logic       sclk_x, cs_n_x, mosi_x, sv_x, sd_x;
    logic [9:0] pots_x;
    logic [2:0] sch_x;

    pot_scanner #(.CHANNELS(4), .CLKDIV(8), .GUARD(16), .SMOOTH(2)) u_dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .adc_sclk(sclk), .adc_cs_n(cs_n), .adc_mosi(mosi), .adc_miso(miso),
        .pots(pots), .sample_valid(sv), .sample_ch(sch), .scan_done(sd)
    );

    pot_scanner #(.CHANNELS(1), .CLKDIV(4), .GUARD(2), .SMOOTH(2)) u_ext (
        .clk(clk), .resetn(resetn), .enable(enable_x),
        .adc_sclk(sclk_x), .adc_cs_n(cs_n_x), .adc_mosi(mosi_x), .adc_miso(1'b1),
        .pots(pots_x), .sample_valid(sv_x), .sample_ch(sch_x), .scan_done(sd_x)
    );

    // ---------------- behavioural MCP3008 ----------------
    logic [9:0]  chan_val [8];
    int          rises = 0;
    int          rise_log = 0;
    logic [23:0] din_sr = '0;
    logic [23:0] frame_log = '0;
    logic [2:0]  model_ch = '0;
    logic        sclk_d = 1'b0;

    initial miso = 1'b0;

    always @(negedge clk) begin
        sclk_d <= sclk;
        if (cs_n) begin
            if (rises != 0) begin
                frame_log <= din_sr;
                rise_log  <= rises;
            end
            rises <= 0;
            miso  <= 1'b0;
        end else begin
            if (sclk && !sclk_d) begin
                din_sr <= {din_sr[22:0], mosi};
                rises  <= rises + 1;
            end
            if (!sclk && sclk_d) begin
                if (rises == 12) model_ch <= din_sr[2:0];
                if (rises >= 14 && rises <= 23) miso <= chan_val[model_ch][23 - rises];
                else                            miso <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wait_sample(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!sv && cyc < limit);
        if (!sv) begin
            checks++; errors++;
            $display("FAIL sample_timeout: no sample_valid after %0d cycles, required within %0d", cyc, limit);
        end
    endtask

    task automatic wait_ch(input logic [2:0] c);
        int cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!(sv && sch == c) && cyc < 5*P);
        if (!(sv && sch == c)) begin
            checks++; errors++;
            $display("FAIL ch_timeout: no sample for ch%0d after %0d cycles", c, cyc);
        end
    endtask

    task automatic wait_rises(input int n);
        int cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (rises != n && cyc < 2*P);
        if (rises != n) begin
            checks++; errors++;
            $display("FAIL rise_timeout: sclk rise %0d not seen, at %0d", n, rises);
        end
    endtask

    typedef struct {
        logic [9:0] raw;
        logic [9:0] exp;
    } smooth_vec_t;
    smooth_vec_t smooth_tab [9];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, c, prev, cur, reached, xr;
        logic sclk_x_prev;

        smooth_tab[0] = '{10'd0,    10'd0};
        smooth_tab[1] = '{10'd1023, 10'd255};
        smooth_tab[2] = '{10'd1023, 10'd447};
        smooth_tab[3] = '{10'd1023, 10'd591};
        smooth_tab[4] = '{10'd1023, 10'd699};
        smooth_tab[5] = '{10'd1023, 10'd780};
        smooth_tab[6] = '{10'd1023, 10'd841};
        smooth_tab[7] = '{10'd1023, 10'd887};
        smooth_tab[8] = '{10'd1023, 10'd921};

        for (int i = 0; i < 8; i++) chan_val[i] = '0;
        chan_val[0] = 10'h2A5; chan_val[1] = 10'h3FF;
        chan_val[2] = 10'h200; chan_val[3] = 10'h155;
        resetn = 1'b0; enable = 1'b0; enable_x = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1); check("rst_sclk", sclk, 0); check("rst_mosi", mosi, 0);
        check("rst_pots", pots, 0); check("rst_valid", sv, 0); check("rst_done", sd, 0);
        check("rst_ch", sch, 0);

        // ---- first conversion ----
        @(negedge clk) resetn = 1'b1;
        @(negedge clk) enable = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (cs_n && cyc < 10);
        check("cs_latency", cyc, 1);
        wait_sample(1000, cyc);
        check("first_latency", cyc, CLKDIV*49 + 1);
        check("first_ch", sch, 0);
        check("first_pot", pots[9:0], 10'h2A5);
        check("first_rises", rise_log, 24);
        check("first_frame", frame_log, 24'h018000);
        check("first_done", sd, 0);

        // ---- round robin and scan_done ----
        @(negedge clk) resetn = 1'b0;
        chan_val[0] = 10'h001;
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_sample(1000, cyc);
            if (i > 0) check("rr_period", cyc, P);
            check("rr_ch", sch, 3'(i % 4));
            check("rr_frame", frame_log, 24'h018000 | (24'(i % 4) << 12));
            check("rr_done", sd, (i == 3) ? 1 : 0);
            if (i == 3) check("rr_pots", pots, {10'h155, 10'h200, 10'h3FF, 10'h001});
        end

        // ---- smoothing (table) ----
        @(negedge clk) resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chan_val[0] = smooth_tab[i].raw;
            wait_ch(3'd0);
            check("smooth_step", pots[9:0], smooth_tab[i].exp);
        end
        prev = 921; reached = 0;
        for (int n = 0; n < 22 && reached == 0; n++) begin
            wait_ch(3'd0);
            cur = int'(pots[9:0]);
            check("smooth_monotonic", (cur >= prev) ? 1 : 0, 1);
            prev = cur;
            if (cur == 1023) reached = 1;
        end
        check("smooth_reached_1023", reached, 1);

        // ---- enable drop mid-frame ----
        wait_rises(11);
        enable = 1'b0;
        wait_sample(1000, cyc);
        check("drop_sample", sv, 1);
        c = int'(sch);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!cs_n || sclk) cyc++;
        end
        check("drop_idle_violations", cyc, 0);
        @(negedge clk) enable = 1'b1;
        wait_sample(1000, cyc);
        check("resume_ch", sch, 3'((c + 1) % 4));
        check("resume_frame_ch", frame_log[14:12], 3'((c + 1) % 4));

        // ---- async reset mid-frame ----
        wait_rises(19);
        #2 resetn = 1'b0;
        #1;
        check("arst_cs_n", cs_n, 1); check("arst_sclk", sclk, 0); check("arst_pots", pots, 0);
        @(negedge clk) resetn = 1'b1;
        wait_sample(1000, cyc);
        check("arst_restart_ch", sch, 0);
        check("arst_direct_load", pots[9:0], 10'h3FF);
        check("arst_frame", frame_log, 24'h018000);

        // ---- extremes: CHANNELS=1, CLKDIV=4, GUARD=2, MISO=1 ----
        @(negedge clk) enable_x = 1'b1;
        sclk_x_prev = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cyc = 0; xr = 0;
            do begin
                @(posedge clk); #1; cyc++;
                if (sclk_x && !sclk_x_prev) xr++;
                sclk_x_prev = sclk_x;
            end while (!sv_x && cyc < 400);
            check("ext_valid", sv_x, 1);
            if (n > 0) check("ext_period", cyc, P_EXT);
            check("ext_sclk_rises", xr, 24);
            check("ext_pot", pots_x, 10'h3FF);
            check("ext_done", sd_x, 1);
            check("ext_ch", sch_x, 0);
            check("ext_cs_high", cs_n_x, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
